// File: rtl/cci_mpf_shim_wro_hash_filter.sv
// ---------------------------------------------------------------------------
// cci_mpf_shim_wro_hash_filter
//
// Counting filter for the write-read-order (WRO) pipeline. It sits right after
// the request buffer/hasher and tracks how many reads (channel 0) and writes
// (channel 1) are outstanding in each address-hash bucket. The upstream stage
// asks it whether the oldest and the next request may proceed.
//
// Ports
//   clk                   clock
//   reset_n               asynchronous, active-low reset
//   c0_hash[0:1]          read hashes to test (index 0 = oldest)
//   c0_hash_conflicts     1 = that read must wait
//   c1_hash[0:1]          write hashes to test (index 0 = oldest)
//   c1_hash_conflicts     1 = that write must wait
//   c0_ins_en/_hash       read issued downstream, bump its bucket
//   c1_ins_en/_hash       write issued downstream, bump its bucket
//   c0_rsp_en/_hash       read response returned, drop its bucket
//   c1_rsp_en/_hash       write ack returned, drop its bucket
//   c1_pipe_notEmpty      at least one write is outstanding
//   err_underflow         sticky: response hit a bucket/total already at 0
//   err_overflow          sticky: insert hit a bucket/total already at max
// ---------------------------------------------------------------------------
module cci_mpf_shim_wro_hash_filter #(
  parameter int ADDRESS_HASH_BITS = 6,
  parameter int COUNTER_BITS      = 3,
  parameter int TOTAL_BITS        = 10
) (
  input  logic                         clk,
  input  logic                         reset_n,

  input  logic [ADDRESS_HASH_BITS-1:0] c0_hash [2],
  output logic                         c0_hash_conflicts [2],
  input  logic [ADDRESS_HASH_BITS-1:0] c1_hash [2],
  output logic                         c1_hash_conflicts [2],

  input  logic                         c0_ins_en,
  input  logic [ADDRESS_HASH_BITS-1:0] c0_ins_hash,
  input  logic                         c1_ins_en,
  input  logic [ADDRESS_HASH_BITS-1:0] c1_ins_hash,
  input  logic                         c0_rsp_en,
  input  logic [ADDRESS_HASH_BITS-1:0] c0_rsp_hash,
  input  logic                         c1_rsp_en,
  input  logic [ADDRESS_HASH_BITS-1:0] c1_rsp_hash,

  output logic                         c1_pipe_notEmpty,
  output logic                         err_underflow,
  output logic                         err_overflow
);

  localparam int N_BUCKETS = 1 << ADDRESS_HASH_BITS;
  localparam logic [COUNTER_BITS-1:0] CMAX      = '1;
  localparam logic [TOTAL_BITS-1:0]   TOTAL_MAX = '1;

  logic [COUNTER_BITS-1:0] rd_cnt_q [N_BUCKETS];
  logic [COUNTER_BITS-1:0] rd_cnt_d [N_BUCKETS];
  logic [COUNTER_BITS-1:0] wr_cnt_q [N_BUCKETS];
  logic [COUNTER_BITS-1:0] wr_cnt_d [N_BUCKETS];
  logic [TOTAL_BITS-1:0]   wr_total_q;
  logic [TOTAL_BITS-1:0]   wr_total_d;
  logic                    err_underflow_q;
  logic                    err_underflow_d;
  logic                    err_overflow_q;
  logic                    err_overflow_d;

  // One-hot decode of each update port onto the bucket it touches.
  logic [N_BUCKETS-1:0] c0_ins_hit;
  logic [N_BUCKETS-1:0] c0_rsp_hit;
  logic [N_BUCKETS-1:0] c1_ins_hit;
  logic [N_BUCKETS-1:0] c1_rsp_hit;

  assign c0_ins_hit = c0_ins_en ? (N_BUCKETS'(1) << c0_ins_hash) : '0;
  assign c0_rsp_hit = c0_rsp_en ? (N_BUCKETS'(1) << c0_rsp_hash) : '0;
  assign c1_ins_hit = c1_ins_en ? (N_BUCKETS'(1) << c1_ins_hash) : '0;
  assign c1_rsp_hit = c1_rsp_en ? (N_BUCKETS'(1) << c1_rsp_hash) : '0;

  // Next-state for every bucket, the write total and the sticky flags.
  // An insert and a response landing on the same counter in the same cycle
  // cancel out, so that case never saturates or flags an error. Otherwise a
  // counter saturates at its limits and raises the matching sticky flag.
  always_comb begin
    err_underflow_d = err_underflow_q;
    err_overflow_d  = err_overflow_q;

    for (int b = 0; b < N_BUCKETS; b++) begin
      rd_cnt_d[b] = rd_cnt_q[b];
      unique case ({c0_ins_hit[b], c0_rsp_hit[b]})
        2'b10: begin
          if (rd_cnt_q[b] == CMAX) err_overflow_d = 1'b1;
          else                     rd_cnt_d[b] = rd_cnt_q[b] + 1'b1;
        end
        2'b01: begin
          if (rd_cnt_q[b] == '0) err_underflow_d = 1'b1;
          else                   rd_cnt_d[b] = rd_cnt_q[b] - 1'b1;
        end
        default: rd_cnt_d[b] = rd_cnt_q[b];
      endcase

      wr_cnt_d[b] = wr_cnt_q[b];
      unique case ({c1_ins_hit[b], c1_rsp_hit[b]})
        2'b10: begin
          if (wr_cnt_q[b] == CMAX) err_overflow_d = 1'b1;
          else                     wr_cnt_d[b] = wr_cnt_q[b] + 1'b1;
        end
        2'b01: begin
          if (wr_cnt_q[b] == '0) err_underflow_d = 1'b1;
          else                   wr_cnt_d[b] = wr_cnt_q[b] - 1'b1;
        end
        default: wr_cnt_d[b] = wr_cnt_q[b];
      endcase
    end

    // The total ignores hashes: any write insert/ack counts.
    wr_total_d = wr_total_q;
    unique case ({c1_ins_en, c1_rsp_en})
      2'b10: begin
        if (wr_total_q == TOTAL_MAX) err_overflow_d = 1'b1;
        else                         wr_total_d = wr_total_q + 1'b1;
      end
      2'b01: begin
        if (wr_total_q == '0) err_underflow_d = 1'b1;
        else                  wr_total_d = wr_total_q - 1'b1;
      end
      default: wr_total_d = wr_total_q;
    endcase
  end

  // State registers; reset discards every outstanding count and both flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < N_BUCKETS; b++) begin
        rd_cnt_q[b] <= '0;
        wr_cnt_q[b] <= '0;
      end
      wr_total_q      <= '0;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      for (int b = 0; b < N_BUCKETS; b++) begin
        rd_cnt_q[b] <= rd_cnt_d[b];
        wr_cnt_q[b] <= wr_cnt_d[b];
      end
      wr_total_q      <= wr_total_d;
      err_underflow_q <= err_underflow_d;
      err_overflow_q  <= err_overflow_d;
    end
  end

  // Zero-latency lookups from registered counts only; in-flight updates of
  // this cycle are not bypassed, the upstream stage handles those itself.
  // Reads only block reads when the read bucket is saturated.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      c0_hash_conflicts[i] = (wr_cnt_q[c0_hash[i]] != '0) ||
                             (rd_cnt_q[c0_hash[i]] == CMAX);
      c1_hash_conflicts[i] = (wr_cnt_q[c1_hash[i]] != '0) ||
                             (rd_cnt_q[c1_hash[i]] != '0);
    end
  end

  assign c1_pipe_notEmpty = (wr_total_q != '0);
  assign err_underflow    = err_underflow_q;
  assign err_overflow     = err_overflow_q;

endmodule
